// File: rtl/riscv_div_unit.sv
// riscv_div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU unit. It uses a radix-2
// restoring divider that produces one quotient bit per clock.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start, funct3       divide instruction present; 1xx selects DIV/DIVU/REM/REMU
//   rs1_data, rs2_data  dividend / divisor from the register file
//   rd_addr             destination register
//   stall               combinational; holds PC/fetch from the issue cycle through FIX
//   busy                high in CALC and FIX
//   done                one-cycle result-valid pulse
//   result              quotient or remainder, held until overwritten
//   wb_addr, wb_en      register-file write port (wb_en suppressed for x0)
module riscv_div_unit #(
   parameter int unsigned DATA_SIZE    = 32,
   parameter int unsigned ADDRESS_SIZE = 5,
   parameter int unsigned CNT_SIZE     = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [2:0]              funct3,
   input  logic [DATA_SIZE-1:0]    rs1_data,
   input  logic [DATA_SIZE-1:0]    rs2_data,
   input  logic [ADDRESS_SIZE-1:0] rd_addr,
   output logic                    stall,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_SIZE-1:0]    result,
   output logic [ADDRESS_SIZE-1:0] wb_addr,
   output logic                    wb_en
);

   localparam int unsigned MSB = DATA_SIZE - 1;
   localparam logic [DATA_SIZE-1:0] MIN_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};
   localparam logic [CNT_SIZE-1:0]  LAST_ITER = CNT_SIZE'(DATA_SIZE - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateType;

   stateType               state;
   logic [DATA_SIZE-1:0]   quo;
   logic [DATA_SIZE-1:0]   remR;
   logic [DATA_SIZE-1:0]   divisor;
   logic [CNT_SIZE-1:0]    cnt;
   logic                   isRem;
   logic                   negQuo;
   logic                   negRem;

   // Decode of the issuing instruction (only meaningful in IDLE)
   logic                   accept;
   logic                   opSigned;
   logic                   opRem;
   logic                   neg1;
   logic                   neg2;
   logic [DATA_SIZE-1:0]   mag1;
   logic [DATA_SIZE-1:0]   mag2;
   logic                   divZero;
   logic                   overflow;
   logic [DATA_SIZE-1:0]   specialVal;

   assign accept   = (state == IDLE) && start && funct3[2];
   assign opSigned = ~funct3[0];
   assign opRem    = funct3[1];
   assign neg1     = opSigned & rs1_data[MSB];
   assign neg2     = opSigned & rs2_data[MSB];
   assign mag1     = neg1 ? -rs1_data : rs1_data;
   assign mag2     = neg2 ? -rs2_data : rs2_data;
   assign divZero  = (rs2_data == '0);
   assign overflow = opSigned && (rs1_data == MIN_NEG) && (rs2_data == '1);

   // Architected results for the cases that skip the iteration
   always_comb begin
      specialVal = '0;
      if (divZero)
         specialVal = opRem ? rs1_data : '1;
      else
         specialVal = opRem ? '0 : MIN_NEG;
   end

   // One restoring step. The compare is one bit wider than the data so that
   // the bit shifted out of the partial remainder is not lost.
   logic [DATA_SIZE:0]     remShift;
   logic                   remGeq;
   logic [DATA_SIZE-1:0]   remSub;
   logic [DATA_SIZE-1:0]   remNext;
   logic [DATA_SIZE-1:0]   quoNext;

   assign remShift = {remR, quo[MSB]};
   assign remGeq   = remShift >= {1'b0, divisor};
   // The true difference is below the divisor, so the low bits are exact
   assign remSub   = remShift[DATA_SIZE-1:0] - divisor;
   assign remNext  = remGeq ? remSub : remShift[DATA_SIZE-1:0];
   assign quoNext  = {quo[MSB-1:0], remGeq};

   // Sign correction applied in FIX
   logic [DATA_SIZE-1:0]   quoFix;
   logic [DATA_SIZE-1:0]   remFix;

   assign quoFix = negQuo ? -quo : quo;
   assign remFix = negRem ? -remR : remR;

   // The issuing cycle stalls before the state register has moved
   assign stall = accept || busy;

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         quo     <= '0;
         remR    <= '0;
         divisor <= '0;
         cnt     <= '0;
         isRem   <= 1'b0;
         negQuo  <= 1'b0;
         negRem  <= 1'b0;
         result  <= '0;
         wb_addr <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wb_en   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done  <= 1'b0;
               wb_en <= 1'b0;
               if (accept) begin
                  quo     <= mag1;
                  divisor <= mag2;
                  remR    <= '0;
                  cnt     <= '0;
                  isRem   <= opRem;
                  negQuo  <= neg1 ^ neg2;
                  negRem  <= neg1;
                  wb_addr <= rd_addr;
                  if (divZero || overflow) begin
                     result <= specialVal;
                     done   <= 1'b1;
                     wb_en  <= (rd_addr != '0);
                     state  <= DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               remR <= remNext;
               quo  <= quoNext;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST_ITER)
                  state <= FIX;
            end
            FIX: begin
               result <= isRem ? remFix : quoFix;
               busy   <= 1'b0;
               done   <= 1'b1;
               wb_en  <= (wb_addr != '0);
               state  <= DONE;
            end
            DONE: begin
               // Start is not accepted here; it must be re-presented in IDLE
               done  <= 1'b0;
               wb_en <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               wb_en <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/riscv_div_unit.md
Name: riscv_div_unit

Overview:
- Multi-cycle RV32M divide/remainder unit for the single-cycle core.
- Consumes the two register-file read operands (rs1/rs2 data) and produces a result plus a write-enable/address pair that drives the register-file write port (DataD/AddrD/RegWEn).
- Asserts a stall to freeze PC and fetch while iterating.
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- DATA_SIZE, 32, operand/result width in bits
- ADDRESS_SIZE, 5, register address width
- CNT_SIZE, 6, iteration counter width; must be able to hold the value DATA_SIZE

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  decoded M-extension divide instruction present this cycle
- funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3[2]=0 is not a divide, and start is ignored
- rs1_data  input  DATA_SIZE  dividend, from register-file DataA
- rs2_data  input  DATA_SIZE  divisor, from register-file DataB
- rd_addr  input  ADDRESS_SIZE  destination register
- stall  output  1  hold PC/fetch
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle result-valid pulse
- result  output  DATA_SIZE  quotient or remainder, held until the next accepted start
- wb_addr  output  ADDRESS_SIZE  to register-file AddrD
- wb_en  output  1  to register-file RegWEn; equals done AND (wb_addr != 0)

Behaviour:

States: IDLE, CALC, FIX, DONE.

Reset (async, rst_n=0):
- state goes to IDLE.
- result, wb_addr, counter, and internal quotient/remainder/divisor registers are cleared to 0.
- done, busy, wb_en are 0.
- Reset mid-operation aborts with no write-back.

IDLE:
- A start with funct3[2]=1 is accepted at the clock edge.
- Latch op (signed = ~funct3[0], rem = funct3[1]), rd_addr, and the operand signs.
- Load |rs1| into the quotient shift register and |rs2| into the divisor; magnitudes apply only for signed ops.
- Clear the partial remainder and counter.
- Special cases bypass CALC and go straight to DONE:
  - Divisor == 0: quotient = all ones (0xFFFFFFFF), remainder = rs1_data unchanged.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM only): quotient = 0x80000000, remainder = 0.
- Otherwise go to CALC.

CALC, one iteration per edge:
- Shift {rem, quo} left by 1.
- If the shifted rem >= divisor, subtract the divisor and set quo[0]=1.
- The counter increments; after exactly DATA_SIZE iterations go to FIX.
- The subtraction uses a DATA_SIZE+1-bit compare; no truncation.

FIX, one edge:
- Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
- Negate the corresponding magnitude when the sign is negative (signed ops only).
- Register the selected value into result and go to DONE.

DONE:
- done=1 for exactly one cycle; wb_en per the rule above.
- Always returns to IDLE at the next edge.
- start in DONE is ignored and must be re-presented in IDLE.

stall = (state==IDLE AND start AND funct3[2]) OR busy. It is combinational, so the issuing cycle stalls. stall is low in DONE, so PC advances on the same edge that writes the register file.

Latency:
- Normal: done is visible after edge 33, counting the accepting edge as edge 0. 34 cycles including DONE.
- Special case: done is visible after edge 0.

Miscellaneous:
- start, funct3 and operands are ignored while busy; latched values are unaffected by input changes.
- result/wb_addr hold their last values in IDLE.

Test Plan:
- DIVU 100/7, rd=5 -> done after 33 edges, result=14, wb_en=1, wb_addr=5; stall high from issue cycle through FIX.
- REM -7 % 2 (0xFFFFFFF9, 2) -> result=0xFFFFFFFF (-1); DIV same operands -> 0xFFFFFFFD (-3).
- DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000 with done after edge 0; REM same operands -> 0.
- DIVU x/0 with x=0x1234 -> 0xFFFFFFFF; REMU x/0 -> 0x1234; both with done after edge 0.
- rd=0 with DIV 10/3 -> done pulses, wb_en stays 0; separately, rst_n low at iteration 16 -> immediate IDLE, no done, no wb_en; the next DIVU 9/3 completes correctly with result 3.
- start toggled and operands changed during CALC -> no effect; result still reflects the originally latched operands; start in DONE is not accepted.
